// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts one fetch at a time over a valid/ready
// handshake, waits WAIT cycles, reads the local store and queues the result in
// a 2-entry response FIFO. flush drops the in-flight fetch and queued responses.
module imem_fetch_responder #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_err,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT > 0) ? CW'(WAIT - 1) : '0;
  // One extra bit so DEPTH == 2**AW is still representable for the range check.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    READ  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          err;
  } entry_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    count_q, count_d;
  entry_t        e0_q, e0_d;
  entry_t        e1_q, e1_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;
  logic          addr_in_range;
  logic          ld_in_range;
  entry_t        new_entry;

  // Handshake and head-of-FIFO outputs.
  assign req_ready     = (state_q == IDLE) && (count_q != 2'd2) && !flush;
  assign accept        = req_valid && req_ready;
  assign rsp_valid     = (count_q != 2'd0);
  assign pop           = rsp_valid && rsp_ready;
  assign rsp_data      = e0_q.data;
  assign rsp_addr      = e0_q.addr;
  assign rsp_err       = e0_q.err;
  assign addr_in_range = ({1'b0, addr_q} < DEPTH_W);
  assign ld_in_range   = ({1'b0, ld_addr} < DEPTH_W);

  // Build the response for the latched address; out-of-range returns a NOP.
  always_comb begin
    new_entry      = '0;
    new_entry.addr = addr_q;
    if (addr_in_range) begin
      new_entry.data = mem_q[addr_q[IW-1:0]];
      new_entry.err  = 1'b0;
    end else begin
      new_entry.data = '0;
      new_entry.err  = 1'b1;
    end
  end

  // Fetch FSM next state: IDLE -> (WAITS) -> READ -> IDLE; flush overrides.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (WAIT == 0) begin
            state_d = READ;
          end else begin
            state_d = WAITS;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAITS: begin
        if (cnt_q == '0) begin
          state_d = READ;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      READ: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      push    = 1'b0;
    end
  end

  // FIFO next state: head is always e0; a pop shifts e1 forward.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_d = new_entry;
          end else begin
            e1_d = new_entry;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = new_entry;
          end else begin
            e0_d = e1_q;
            e1_d = new_entry;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Control and FIFO registers; cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  // Latched fetch address and instruction store; the store survives reset and
  // a same-edge load to the address being read returns the old word.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (ld_en && ld_in_range) begin
      mem_q[ld_addr[IW-1:0]] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: three instances (WAIT = 1, 0, 3) checked every
// cycle against a queue-based model, plus directed literal expectations.
module tb_imem_fetch_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [15:0] req_addr [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [15:0] rsp_data [3];
  logic [15:0] rsp_addr [3];
  logic [2:0]  rsp_err;
  logic [2:0]  flush;
  logic [2:0]  ld_en;
  logic [15:0] ld_addr [3];
  logic [15:0] ld_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch_responder #(
      .AW(16), .DW(16), .DEPTH(256), .WAIT(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .rsp_addr(rsp_addr[g]), .rsp_err(rsp_err[g]), .flush(flush[g]),
      .ld_en(ld_en[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a response queue per instance, a pending fetch with a countdown of
  // edges until its push, and a shadow copy of each store.
  typedef struct {
    logic [15:0] d;
    logic [15:0] a;
    bit          e;
    bit          known;
  } rsp_t;

  rsp_t        mq [3][$];
  bit          m_busy [3];
  logic [15:0] m_addr [3];
  int          m_left [3];
  bit          m_zero [3];
  logic [15:0] mm [3][256];
  bit          mk [3][256];
  int          wv [3] = '{1, 0, 3};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      m_busy[k] = 1'b0;
      m_left[k] = 0;
      m_zero[k] = 1'b1;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit   acc;
    bit   pop;
    bit   pushing;
    rsp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        acc     = req_valid[k] && !m_busy[k] && (mq[k].size() < 2) && !flush[k];
        pop     = (mq[k].size() > 0) && rsp_ready[k];
        pushing = 1'b0;
        e       = '{d: 16'h0, a: 16'h0, e: 1'b0, known: 1'b1};
        if (m_busy[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            pushing   = 1'b1;
            m_busy[k] = 1'b0;
            e.a       = m_addr[k];
            if (m_addr[k] < 16'd256) begin
              e.d     = mm[k][m_addr[k][7:0]];
              e.known = mk[k][m_addr[k][7:0]];
              e.e     = 1'b0;
            end else begin
              e.d     = 16'h0;
              e.known = 1'b1;
              e.e     = 1'b1;
            end
          end
        end
        if (flush[k]) begin
          mq[k].delete();
          m_busy[k] = 1'b0;
        end else begin
          if (pop) void'(mq[k].pop_front());
          if (pushing) begin
            mq[k].push_back(e);
            m_zero[k] = 1'b0;
          end
          if (acc) begin
            m_busy[k] = 1'b1;
            m_addr[k] = req_addr[k];
            m_left[k] = wv[k] + 1;
          end
        end
        if (ld_en[k] && (ld_addr[k] < 16'd256)) begin
          mm[k][ld_addr[k][7:0]] = ld_data[k];
          mk[k][ld_addr[k][7:0]] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i%0d rsp_valid", k), 32'(rsp_valid[k]), 32'(mq[k].size() > 0));
      check($sformatf("i%0d req_ready", k), 32'(req_ready[k]),
            32'(!m_busy[k] && (mq[k].size() < 2) && !flush[k]));
      if (mq[k].size() > 0) begin
        if (mq[k][0].known) check($sformatf("i%0d rsp_data", k), 32'(rsp_data[k]), 32'(mq[k][0].d));
        check($sformatf("i%0d rsp_addr", k), 32'(rsp_addr[k]), 32'(mq[k][0].a));
        check($sformatf("i%0d rsp_err", k), 32'(rsp_err[k]), 32'(mq[k][0].e));
      end else if (m_zero[k]) begin
        check($sformatf("i%0d reset rsp_data", k), 32'(rsp_data[k]), 32'h0);
        check($sformatf("i%0d reset rsp_addr", k), 32'(rsp_addr[k]), 32'h0);
        check($sformatf("i%0d reset rsp_err", k), 32'(rsp_err[k]), 32'h0);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic load(input int k, input logic [15:0] a, input logic [15:0] d);
    ld_en[k]   = 1'b1;
    ld_addr[k] = a;
    ld_data[k] = d;
    tick();
    ld_en[k] = 1'b0;
  endtask

  // Present a request and return after the edge that accepted it.
  task automatic fetch(input int k, input logic [15:0] a);
    int n    = 0;
    bit done = 1'b0;
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    while (!done && n < 40) begin
      done = req_ready[k];
      tick();
      n++;
    end
    req_valid[k] = 1'b0;
    check($sformatf("i%0d accept %0h", k, a), 32'(done), 32'h1);
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    while (!rsp_valid[k] && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("i%0d rsp_valid arrives", k), 32'(rsp_valid[k]), 32'h1);
  endtask

  task automatic pop_expect(input int k, input logic [15:0] d, input logic [15:0] a);
    wait_valid(k);
    check($sformatf("i%0d pop data @%0h", k, a), 32'(rsp_data[k]), 32'(d));
    check($sformatf("i%0d pop addr", k), 32'(rsp_addr[k]), 32'(a));
    check($sformatf("i%0d pop err", k), 32'(rsp_err[k]), 32'h0);
    rsp_ready[k] = 1'b1;
    tick();
    rsp_ready[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got [$];
    logic [15:0] exp3 [3];
    bit          acc_next;
    int          n;

    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    flush     = '0;
    ld_en     = '0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = '0;
      ld_addr[k]  = '0;
      ld_data[k]  = '0;
      for (int i = 0; i < 256; i++) begin
        mm[k][i] = '0;
        mk[k][i] = 1'b0;
      end
    end
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    check("reset rsp_valid", 32'(rsp_valid[0]), 32'h0);
    check("reset req_ready", 32'(req_ready[0]), 32'h1);
    check("reset rsp_data", 32'(rsp_data[0]), 32'h0);

    // Basic fetch, WAIT=1: response visible after E+2.
    load(0, 16'd5, 16'hA5A5);
    fetch(0, 16'd5);
    check("t1 ready in WAITS", 32'(req_ready[0]), 32'h0);
    check("t1 valid at E+1", 32'(rsp_valid[0]), 32'h0);
    tick();
    check("t1 ready in READ", 32'(req_ready[0]), 32'h0);
    check("t1 valid before E+2", 32'(rsp_valid[0]), 32'h0);
    tick();
    check("t1 valid at E+2", 32'(rsp_valid[0]), 32'h1);
    check("t1 data", 32'(rsp_data[0]), 32'hA5A5);
    check("t1 addr", 32'(rsp_addr[0]), 32'h5);
    check("t1 err", 32'(rsp_err[0]), 32'h0);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;

    // Backpressure, WAIT=0: two queued, third stalls, then drain in order.
    load(1, 16'd1, 16'd11);
    load(1, 16'd2, 16'd22);
    load(1, 16'd3, 16'd33);
    fetch(1, 16'd1);
    fetch(1, 16'd2);
    req_valid[1] = 1'b1;
    req_addr[1]  = 16'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2 stalled ready", 32'(req_ready[1]), 32'h0);
    end
    rsp_ready[1] = 1'b1;
    n = 0;
    while (got.size() < 3 && n < 30) begin
      if (rsp_valid[1]) got.push_back(rsp_data[1]);
      acc_next = req_valid[1] && req_ready[1];
      tick();
      if (acc_next) req_valid[1] = 1'b0;
      n++;
    end
    rsp_ready[1] = 1'b0;
    req_valid[1] = 1'b0;
    exp3 = '{16'd11, 16'd22, 16'd33};
    check("t2 pop count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2 pop %0d", i), 32'((i < got.size()) ? got[i] : 16'hDEAD), 32'(exp3[i]));
    for (int i = 0; i < 3; i++) tick();
    check("t2 no duplicate", 32'(rsp_valid[1]), 32'h0);

    // Out of range: NOP with error, and loads beyond the store are dropped.
    load(0, 16'd0, 16'h1234);
    fetch(0, 16'h0100);
    wait_valid(0);
    check("t3 oor data", 32'(rsp_data[0]), 32'h0);
    check("t3 oor err", 32'(rsp_err[0]), 32'h1);
    check("t3 oor addr", 32'(rsp_addr[0]), 32'h0100);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    load(0, 16'h0100, 16'hBEEF);
    fetch(0, 16'd0);
    pop_expect(0, 16'h1234, 16'd0);

    // Flush, WAIT=3: one queued response plus a fetch in WAITS.
    load(2, 16'd7, 16'h0777);
    load(2, 16'd8, 16'h0888);
    load(2, 16'd9, 16'h0999);
    fetch(2, 16'd9);
    wait_valid(2);
    fetch(2, 16'd7);
    tick();
    flush[2] = 1'b1;
    tick();
    check("t4 valid after flush", 32'(rsp_valid[2]), 32'h0);
    check("t4 ready while flush", 32'(req_ready[2]), 32'h0);
    flush[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t4 no late push", 32'(rsp_valid[2]), 32'h0);
    end
    flush[2]     = 1'b1;
    req_valid[2] = 1'b1;
    req_addr[2]  = 16'd9;
    #1;
    check("t4 ready masked by flush", 32'(req_ready[2]), 32'h0);
    tick();
    flush[2]     = 1'b0;
    req_valid[2] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t4 flushed request dropped", 32'(rsp_valid[2]), 32'h0);
    fetch(2, 16'd8);
    pop_expect(2, 16'h0888, 16'd8);

    // Push and pop on the same edge at count=1, WAIT=0.
    load(1, 16'd10, 16'hAAAA);
    load(1, 16'd11, 16'hBBBB);
    fetch(1, 16'd10);
    wait_valid(1);
    fetch(1, 16'd11);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    check("t5 pp valid", 32'(rsp_valid[1]), 32'h1);
    check("t5 pp head", 32'(rsp_data[1]), 32'hBBBB);
    tick();
    check("t5 pp head held", 32'(rsp_data[1]), 32'hBBBB);
    pop_expect(1, 16'hBBBB, 16'd11);
    check("t5 pp count 1", 32'(rsp_valid[1]), 32'h0);

    // Load to the address being read, WAIT=1: old word first, new word later.
    load(0, 16'd4, 16'h4444);
    fetch(0, 16'd4);
    tick();
    ld_en[0]   = 1'b1;
    ld_addr[0] = 16'd4;
    ld_data[0] = 16'h4E4E;
    tick();
    ld_en[0] = 1'b0;
    pop_expect(0, 16'h4444, 16'd4);
    fetch(0, 16'd4);
    pop_expect(0, 16'h4E4E, 16'd4);

    // Asynchronous reset mid-fetch, WAIT=3.
    load(2, 16'd12, 16'h0C0C);
    load(2, 16'd13, 16'h0D0D);
    fetch(2, 16'd12);
    wait_valid(2);
    fetch(2, 16'd13);
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("t6 async valid", 32'(rsp_valid[2]), 32'h0);
    check("t6 async data", 32'(rsp_data[2]), 32'h0);
    check("t6 async addr", 32'(rsp_addr[2]), 32'h0);
    check("t6 async err", 32'(rsp_err[2]), 32'h0);
    @(negedge clk);
    tick();
    rst = 1'b1;
    #1;
    check("t6 ready after reset", 32'(req_ready[2]), 32'h1);
    for (int i = 0; i < 8; i++) tick();
    check("t6 no stale response", 32'(rsp_valid[2]), 32'h0);
    fetch(2, 16'd13);
    pop_expect(2, 16'h0D0D, 16'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
